// File: rtl/dcache_lsu_master_if.sv
// Pipeline request/response and dcache cmd/rsp signals of the load/store master.
// master = the LSU side; slave = pipeline stage plus dcache responder.
interface dcache_lsu_master_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        req_wen;
    logic [63:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        dcache_cmd_valid;
    logic        dcache_cmd_ready;
    logic [63:0] dcache_cmd_payload_addr;
    logic        dcache_cmd_payload_wen;
    logic [63:0] dcache_cmd_payload_wdata;
    logic [7:0]  dcache_cmd_payload_wstrb;
    logic [2:0]  dcache_cmd_payload_size;
    logic        dcache_rsp_valid;
    logic [63:0] dcache_rsp_payload_data;

    modport master (
        input  req_valid, req_addr, req_wen, req_wdata, req_size, req_unsigned,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output dcache_cmd_valid, dcache_cmd_payload_addr, dcache_cmd_payload_wen,
        output dcache_cmd_payload_wdata, dcache_cmd_payload_wstrb, dcache_cmd_payload_size,
        input  dcache_cmd_ready, dcache_rsp_valid, dcache_rsp_payload_data
    );

    modport slave (
        output req_valid, req_addr, req_wen, req_wdata, req_size, req_unsigned,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  dcache_cmd_valid, dcache_cmd_payload_addr, dcache_cmd_payload_wen,
        input  dcache_cmd_payload_wdata, dcache_cmd_payload_wstrb, dcache_cmd_payload_size,
        output dcache_cmd_ready, dcache_rsp_valid, dcache_rsp_payload_data
    );
endinterface

// File: rtl/dcache_lsu_master.sv
// Single-outstanding load/store initiator for the dcache cmd/rsp port:
// aligns commands to doublewords, extracts/extends load lanes, reports errors and timeouts.
module dcache_lsu_master #(
    parameter int unsigned RSP_TIMEOUT = 16,
    parameter logic [63:0] PC_BASE     = 64'h8000_0000
) (
    input  logic                clock,
    input  logic                reset,
    dcache_lsu_master_if.master bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CMD      = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t      state_r;
    logic [7:0]  timeout_cnt_r;
    logic [2:0]  lane_off_r;
    logic [1:0]  size_r;
    logic        unsigned_r;
    logic        req_ready_r;
    logic        resp_valid_r;
    logic [63:0] resp_rdata_r;
    logic        resp_err_r;
    logic        cmd_valid_r;
    logic [63:0] cmd_addr_r;
    logic        cmd_wen_r;
    logic [63:0] cmd_wdata_r;
    logic [7:0]  cmd_wstrb_r;
    logic [2:0]  cmd_size_r;

    logic        req_fire_s;
    logic        req_err_s;
    logic [63:0] load_data_s;

    function automatic logic misaligned_f(input logic [1:0] size, input logic [2:0] addr_lo);
        logic m;
        case (size)
            2'd0:    m = 1'b0;
            2'd1:    m = addr_lo[0];
            2'd2:    m = |addr_lo[1:0];
            2'd3:    m = |addr_lo[2:0];
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [7:0] size_mask_f(input logic [1:0] size);
        logic [7:0] mask;
        case (size)
            2'd0:    mask = 8'h01;
            2'd1:    mask = 8'h03;
            2'd2:    mask = 8'h0F;
            2'd3:    mask = 8'hFF;
            default: mask = 8'h00;
        endcase
        return mask;
    endfunction

    // Doubleword size ignores the unsigned flag: there is nothing left to extend.
    function automatic logic [63:0] extract_load_f(input logic [63:0] data, input logic [2:0] off,
                                                   input logic [1:0] size, input logic uns);
        logic [63:0] lane;
        logic [63:0] res;
        lane = data >> {off, 3'b000};
        case (size)
            2'd0:    res = uns ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
            2'd1:    res = uns ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
            2'd2:    res = uns ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
            2'd3:    res = lane;
            default: res = lane;
        endcase
        return res;
    endfunction

    // Request decode and load lane extraction.
    always_comb begin
        req_fire_s  = bus.req_valid & req_ready_r;
        req_err_s   = misaligned_f(bus.req_size, bus.req_addr[2:0]) | (bus.req_addr < PC_BASE);
        load_data_s = extract_load_f(bus.dcache_rsp_payload_data, lane_off_r, size_r, unsigned_r);
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= IDLE;
            timeout_cnt_r <= 8'd0;
            lane_off_r    <= 3'd0;
            size_r        <= 2'd0;
            unsigned_r    <= 1'b0;
            req_ready_r   <= 1'b1;
            resp_valid_r  <= 1'b0;
            resp_rdata_r  <= 64'd0;
            resp_err_r    <= 1'b0;
            cmd_valid_r   <= 1'b0;
            cmd_addr_r    <= 64'd0;
            cmd_wen_r     <= 1'b0;
            cmd_wdata_r   <= 64'd0;
            cmd_wstrb_r   <= 8'd0;
            cmd_size_r    <= 3'd0;
        end else begin
            resp_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_fire_s) begin
                        req_ready_r <= 1'b0;
                        lane_off_r  <= bus.req_addr[2:0];
                        size_r      <= bus.req_size;
                        unsigned_r  <= bus.req_unsigned;
                        if (req_err_s) begin
                            state_r      <= DONE;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_rdata_r <= 64'd0;
                        end else begin
                            state_r     <= CMD;
                            cmd_valid_r <= 1'b1;
                            cmd_addr_r  <= {bus.req_addr[63:3], 3'b000};
                            cmd_wen_r   <= bus.req_wen;
                            cmd_size_r  <= {1'b0, bus.req_size};
                            // Loads carry no strobes or data on the bus.
                            if (bus.req_wen) begin
                                cmd_wstrb_r <= size_mask_f(bus.req_size) << bus.req_addr[2:0];
                                cmd_wdata_r <= bus.req_wdata << {bus.req_addr[2:0], 3'b000};
                            end else begin
                                cmd_wstrb_r <= 8'd0;
                                cmd_wdata_r <= 64'd0;
                            end
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                CMD: begin
                    if (bus.dcache_cmd_ready) begin
                        cmd_valid_r <= 1'b0;
                        if (cmd_wen_r) begin
                            state_r      <= DONE;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b0;
                            resp_rdata_r <= 64'd0;
                        end else begin
                            state_r       <= WAIT_RSP;
                            timeout_cnt_r <= 8'd0;
                        end
                    end else begin
                        cmd_valid_r <= 1'b1;
                    end
                end
                WAIT_RSP: begin
                    // A response in the final allowed cycle beats the timeout.
                    if (bus.dcache_rsp_valid) begin
                        state_r      <= DONE;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b0;
                        resp_rdata_r <= load_data_s;
                    end else if (timeout_cnt_r == 8'(RSP_TIMEOUT - 1)) begin
                        state_r      <= DONE;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b1;
                        resp_rdata_r <= 64'd0;
                    end else begin
                        timeout_cnt_r <= timeout_cnt_r + 8'd1;
                    end
                end
                DONE: begin
                    state_r     <= IDLE;
                    req_ready_r <= 1'b1;
                end
                default: begin
                    state_r     <= IDLE;
                    req_ready_r <= 1'b1;
                    cmd_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready                = req_ready_r;
    assign bus.resp_valid               = resp_valid_r;
    assign bus.resp_rdata               = resp_rdata_r;
    assign bus.resp_err                 = resp_err_r;
    assign bus.dcache_cmd_valid         = cmd_valid_r;
    assign bus.dcache_cmd_payload_addr  = cmd_addr_r;
    assign bus.dcache_cmd_payload_wen   = cmd_wen_r;
    assign bus.dcache_cmd_payload_wdata = cmd_wdata_r;
    assign bus.dcache_cmd_payload_wstrb = cmd_wstrb_r;
    assign bus.dcache_cmd_payload_size  = cmd_size_r;

endmodule

// File: tb/tb_dcache_lsu_master.sv
// Scoreboard bench for dcache_lsu_master: directed requests push expected commands and
// responses; an independent monitor pops and compares whenever the DUT presents them.
module tb_dcache_lsu_master;

    localparam int RSP_TIMEOUT = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   resp_count = 0;
    int   cmd_count = 0;
    int   accept_cyc = 0;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
    } resp_exp_t;

    typedef struct {
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [2:0]  size;
    } cmd_exp_t;

    resp_exp_t resp_q[$];
    cmd_exp_t  cmd_q[$];

    dcache_lsu_master_if bus ();

    dcache_lsu_master #(.RSP_TIMEOUT(RSP_TIMEOUT), .PC_BASE(64'h8000_0000)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: compares every completion and every command handshake against the queues.
    initial begin
        resp_exp_t e;
        cmd_exp_t  c;
        forever begin
            @(negedge clock);
            if (!reset && bus.resp_valid) begin
                resp_count++;
                if (resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp actual=1 expected=0 at cycle %0d", cyc);
                end else begin
                    e = resp_q.pop_front();
                    check64("resp_rdata", bus.resp_rdata, e.rdata);
                    check64("resp_err", {63'd0, bus.resp_err}, {63'd0, e.err});
                    if (e.lat >= 0) check64("resp_latency", 64'(cyc - accept_cyc), 64'(e.lat));
                end
            end
            if (!reset && bus.dcache_cmd_valid) begin
                if (cmd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cmd actual=1 expected=0 at cycle %0d", cyc);
                end else if (bus.dcache_cmd_ready) begin
                    c = cmd_q.pop_front();
                    cmd_count++;
                    check64("cmd_addr", bus.dcache_cmd_payload_addr, c.addr);
                    check64("cmd_wen", {63'd0, bus.dcache_cmd_payload_wen}, {63'd0, c.wen});
                    check64("cmd_wstrb", {56'd0, bus.dcache_cmd_payload_wstrb}, {56'd0, c.wstrb});
                    check64("cmd_size", {61'd0, bus.dcache_cmd_payload_size}, {61'd0, c.size});
                    if (c.wen) check64("cmd_wdata", bus.dcache_cmd_payload_wdata, c.wdata);
                end
            end
        end
    end

    // Presents one request, plays the cmd/rsp responder, and queues expectations.
    task automatic issue(input logic [63:0] addr, input logic wen, input logic [63:0] wdata,
                         input logic [1:0] size, input logic uns,
                         input logic exp_cmd, input logic [63:0] exp_caddr,
                         input logic [7:0] exp_wstrb, input logic [63:0] exp_wdata,
                         input int ready_delay, input logic send_rsp, input int rsp_delay,
                         input logic [63:0] rsp_data, input logic push_resp,
                         input logic [63:0] exp_rdata, input logic exp_err, input int exp_lat);
        cmd_exp_t  c;
        resp_exp_t r;
        c.addr  = exp_caddr;
        c.wen   = wen;
        c.wdata = exp_wdata;
        c.wstrb = exp_wstrb;
        c.size  = {1'b0, size};
        if (exp_cmd) cmd_q.push_back(c);
        r.rdata = exp_rdata;
        r.err   = exp_err;
        r.lat   = exp_lat;
        if (push_resp) resp_q.push_back(r);

        check64("req_ready_idle", {63'd0, bus.req_ready}, 64'd1);
        bus.req_valid    = 1'b1;
        bus.req_addr     = addr;
        bus.req_wen      = wen;
        bus.req_wdata    = wdata;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        accept_cyc       = cyc;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        if (exp_cmd) begin
            bus.dcache_cmd_ready = 1'b0;
            for (int i = 0; i < ready_delay; i++) begin
                check64("cmd_valid_held", {63'd0, bus.dcache_cmd_valid}, 64'd1);
                check64("cmd_addr_held", bus.dcache_cmd_payload_addr, exp_caddr);
                check64("cmd_wstrb_held", {56'd0, bus.dcache_cmd_payload_wstrb}, {56'd0, exp_wstrb});
                @(posedge clock);
                #1;
            end
            check64("cmd_valid_at_ready", {63'd0, bus.dcache_cmd_valid}, 64'd1);
            bus.dcache_cmd_ready = 1'b1;
            @(posedge clock);
            #1;
            bus.dcache_cmd_ready = 1'b0;
            if (send_rsp) begin
                for (int i = 0; i < rsp_delay; i++) begin
                    @(posedge clock);
                    #1;
                end
                bus.dcache_rsp_valid        = 1'b1;
                bus.dcache_rsp_payload_data = rsp_data;
                @(posedge clock);
                #1;
                bus.dcache_rsp_valid = 1'b0;
            end
        end
    endtask

    // Bounded wait for the monitor to see the target number of completions.
    task automatic wait_resp(input int target);
        int n;
        n = 0;
        while (resp_count < target && n < 60) begin
            @(posedge clock);
            n++;
        end
        #1;
        check64("resp_arrived", {63'd0, resp_count >= target}, 64'd1);
    endtask

    localparam logic [63:0] LB_DATA = 64'h80FF_0000_0000_0000;
    localparam logic [63:0] LW_DATA = 64'h8765_4321_0000_0000;

    initial begin
        int n;
        bus.req_valid               = 1'b0;
        bus.req_addr                = 64'd0;
        bus.req_wen                 = 1'b0;
        bus.req_wdata               = 64'd0;
        bus.req_size                = 2'd0;
        bus.req_unsigned            = 1'b0;
        bus.dcache_cmd_ready        = 1'b0;
        bus.dcache_rsp_valid        = 1'b0;
        bus.dcache_rsp_payload_data = 64'd0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check64("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
        check64("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        check64("rst_resp_err", {63'd0, bus.resp_err}, 64'd0);
        check64("rst_resp_rdata", bus.resp_rdata, 64'd0);
        check64("rst_cmd_valid", {63'd0, bus.dcache_cmd_valid}, 64'd0);
        check64("rst_cmd_addr", bus.dcache_cmd_payload_addr, 64'd0);
        check64("rst_cmd_wstrb", {56'd0, bus.dcache_cmd_payload_wstrb}, 64'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Byte loads across lanes of one doubleword
        n = resp_count;
        issue(64'h8000_0013, 1'b0, 64'd0, 2'd0, 1'b0, 1'b1, 64'h8000_0010, 8'h00, 64'd0,
              0, 1'b1, 0, LB_DATA, 1'b1, 64'h0, 1'b0, 3);
        wait_resp(n + 1);
        n = resp_count;
        issue(64'h8000_0016, 1'b0, 64'd0, 2'd0, 1'b0, 1'b1, 64'h8000_0010, 8'h00, 64'd0,
              0, 1'b1, 0, LB_DATA, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3);
        wait_resp(n + 1);
        n = resp_count;
        issue(64'h8000_0017, 1'b0, 64'd0, 2'd0, 1'b0, 1'b1, 64'h8000_0010, 8'h00, 64'd0,
              0, 1'b1, 0, LB_DATA, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 3);
        wait_resp(n + 1);

        // Stores: SH in the top lane, SB with truncated shifted data and backpressure
        n = resp_count;
        issue(64'h8000_0106, 1'b1, 64'h0000_0000_0000_BEEF, 2'd1, 1'b0, 1'b1, 64'h8000_0100,
              8'hC0, 64'hBEEF_0000_0000_0000, 0, 1'b0, 0, 64'd0, 1'b1, 64'h0, 1'b0, 2);
        wait_resp(n + 1);
        n = resp_count;
        issue(64'h8000_0005, 1'b1, 64'h1234_5678_9ABC_DEF0, 2'd0, 1'b0, 1'b1, 64'h8000_0000,
              8'h20, 64'hBCDE_F000_0000_0000, 2, 1'b0, 0, 64'd0, 1'b1, 64'h0, 1'b0, 4);
        wait_resp(n + 1);

        // Word loads, unsigned then signed
        n = resp_count;
        issue(64'h8000_0004, 1'b0, 64'd0, 2'd2, 1'b1, 1'b1, 64'h8000_0000, 8'h00, 64'd0,
              0, 1'b1, 0, LW_DATA, 1'b1, 64'h0000_0000_8765_4321, 1'b0, 3);
        wait_resp(n + 1);
        n = resp_count;
        issue(64'h8000_0004, 1'b0, 64'd0, 2'd2, 1'b0, 1'b1, 64'h8000_0000, 8'h00, 64'd0,
              0, 1'b1, 0, LW_DATA, 1'b1, 64'hFFFF_FFFF_8765_4321, 1'b0, 3);
        wait_resp(n + 1);

        // Error requests never reach the bus
        n = resp_count;
        issue(64'h8000_0004, 1'b1, 64'h1111_2222_3333_4444, 2'd3, 1'b0, 1'b0, 64'd0, 8'h00,
              64'd0, 0, 1'b0, 0, 64'd0, 1'b1, 64'h0, 1'b1, 1);
        check64("misaligned_no_cmd", {63'd0, bus.dcache_cmd_valid}, 64'd0);
        wait_resp(n + 1);
        n = resp_count;
        issue(64'h7FFF_FFF8, 1'b0, 64'd0, 2'd3, 1'b0, 1'b0, 64'd0, 8'h00,
              64'd0, 0, 1'b0, 0, 64'd0, 1'b1, 64'h0, 1'b1, 1);
        check64("range_no_cmd", {63'd0, bus.dcache_cmd_valid}, 64'd0);
        wait_resp(n + 1);

        // Backpressure for 5 cycles, then a response timeout and a stray late response
        n = resp_count;
        issue(64'h8000_0008, 1'b0, 64'd0, 2'd3, 1'b0, 1'b1, 64'h8000_0008, 8'h00, 64'd0,
              5, 1'b0, 0, 64'd0, 1'b1, 64'h0, 1'b1, 5 + 2 + RSP_TIMEOUT);
        wait_resp(n + 1);
        n = resp_count;
        bus.dcache_rsp_valid        = 1'b1;
        bus.dcache_rsp_payload_data = 64'h5555_AAAA_5555_AAAA;
        @(posedge clock);
        #1;
        bus.dcache_rsp_valid = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check64("stray_rsp_ignored", 64'(resp_count), 64'(n));
        check64("rdata_held", bus.resp_rdata, 64'd0);
        check64("err_held", {63'd0, bus.resp_err}, 64'd1);
        check64("single_handshake", 64'(cmd_count), 64'd8);

        // Response in the last allowed WAIT_RSP cycle wins over the timeout
        n = resp_count;
        issue(64'h8000_0002, 1'b0, 64'd0, 2'd1, 1'b0, 1'b1, 64'h8000_0000, 8'h00, 64'd0,
              0, 1'b1, RSP_TIMEOUT - 1, 64'h0000_0000_8001_0000, 1'b1,
              64'hFFFF_FFFF_FFFF_8001, 1'b0, 3 + RSP_TIMEOUT - 1);
        wait_resp(n + 1);

        // Reset while waiting for a response
        n = resp_count;
        issue(64'h8000_0020, 1'b0, 64'd0, 2'd3, 1'b0, 1'b1, 64'h8000_0020, 8'h00, 64'd0,
              0, 1'b0, 0, 64'd0, 1'b0, 64'h0, 1'b0, -1);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check64("mid_rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
        check64("mid_rst_cmd_valid", {63'd0, bus.dcache_cmd_valid}, 64'd0);
        check64("mid_rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        repeat (3) @(posedge clock);
        #1;
        check64("mid_rst_no_resp", 64'(resp_count), 64'(n));

        // Back-to-back loads after the reset
        n = resp_count;
        issue(64'h8000_0020, 1'b0, 64'd0, 2'd3, 1'b1, 1'b1, 64'h8000_0020, 8'h00, 64'd0,
              0, 1'b1, 0, 64'hDEAD_BEEF_0123_4567, 1'b1, 64'hDEAD_BEEF_0123_4567, 1'b0, 3);
        wait_resp(n + 1);
        n = resp_count;
        issue(64'h8000_0024, 1'b0, 64'd0, 2'd2, 1'b1, 1'b1, 64'h8000_0020, 8'h00, 64'd0,
              0, 1'b1, 0, 64'hDEAD_BEEF_0123_4567, 1'b1, 64'h0000_0000_DEAD_BEEF, 1'b0, 3);
        wait_resp(n + 1);

        repeat (2) @(posedge clock);
        check64("resp_queue_drained", 64'(resp_q.size()), 64'd0);
        check64("cmd_queue_drained", 64'(cmd_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dcache_lsu_master.md
Name: dcache_lsu_master

Overview:
- Load/store initiator for the core's dcache cmd/rsp interface. The data RAM model in the sim top is the responder on the other end.
- Accepts one memory request at a time from the execute/memory stage and drives a doubleword-aligned command with byte strobes.
- For loads, waits for the response, extracts the addressed lane, and sign- or zero-extends it.
- Reports completion, misalignment errors and response timeouts back to the pipeline.

Parameters:
- RSP_TIMEOUT, 16, maximum cycles spent in WAIT_RSP before an error completion (legal range 2..255).
- PC_BASE, 64'h8000_0000, lowest legal address; requests below it complete with an error.

Ports:
- clock  in  1  system clock
- reset  in  1  reset
- req_valid  in  1  pipeline request valid
- req_ready  out  1  master can accept a request
- req_addr  in  64  byte address
- req_wen  in  1  1 = store, 0 = load
- req_wdata  in  64  store data, right-aligned
- req_size  in  2  access size: 0 = B, 1 = H, 2 = W, 3 = D
- req_unsigned  in  1  zero-extend load result
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  64  extended load data (0 for stores and errors)
- resp_err  out  1  misaligned, out-of-range or timed out
- dcache_cmd_valid  out  1  command valid
- dcache_cmd_ready  in  1  responder accepts command
- dcache_cmd_payload_addr  out  64  request address with bits [2:0] cleared
- dcache_cmd_payload_wen  out  1  write enable
- dcache_cmd_payload_wdata  out  64  lane-shifted store data
- dcache_cmd_payload_wstrb  out  8  byte strobes
- dcache_cmd_payload_size  out  3  {1'b0, req_size}
- dcache_rsp_valid  in  1  read data valid
- dcache_rsp_payload_data  in  64  aligned doubleword

Behaviour:
- Reset and clock: reset is synchronous, active-high; clock is `clock`.
- Reset values: state = IDLE. req_ready = 1. resp_valid = 0, resp_err = 0, resp_rdata = 0. dcache_cmd_valid = 0. All cmd payload registers = 0. Timeout counter = 0.
- Request acceptance: req_ready = (state == IDLE). A request is latched on the edge where req_valid & req_ready.
- Misalignment check: misaligned = (size 1 & addr[0]) | (size 2 & addr[1:0] != 0) | (size 3 & addr[2:0] != 0).
- Out of range: req_addr < PC_BASE.
- Error request (misaligned or out of range): no command is issued; state goes to DONE; resp_err = 1, resp_rdata = 0.
- States:
  - IDLE: on accept, go to CMD (or DONE on an error request).
  - CMD: dcache_cmd_valid = 1, payload held stable until dcache_cmd_ready. On the handshake, a store goes to DONE and a load goes to WAIT_RSP.
  - WAIT_RSP: counter increments each cycle. On dcache_rsp_valid, capture the data and go to DONE. If the counter reaches RSP_TIMEOUT without a response, go to DONE with resp_err = 1.
  - DONE: resp_valid = 1 for exactly one cycle, then IDLE.
- Strobes and store data: wstrb = size mask (0x01, 0x03, 0x0F, 0xFF) << addr[2:0]; wdata = req_wdata << (8 * addr[2:0]).
- Load extraction: lane = rsp_data >> (8 * addr[2:0]), truncated to the access size, then sign-extended unless req_unsigned. Size D ignores req_unsigned.
- Latency with cmd_ready = 1 and a 1-cycle responder, request accepted at edge T:
  - cmd_valid high in cycle T+1.
  - Store: resp_valid in cycle T+2.
  - Load: rsp_valid in T+2, resp_valid in T+3.
- Backpressure: cmd_ready low holds CMD indefinitely with the payload stable. No timeout applies in CMD.
- rsp_valid outside WAIT_RSP is ignored (covers a late response after a timeout).
- rsp_valid arriving in the same cycle the counter reaches RSP_TIMEOUT: the response wins and resp_err = 0.
- Reset mid-operation: immediate return to IDLE with no resp_valid. An in-flight command is dropped; cmd_valid = 0 on the following cycle.
- resp_rdata and resp_err hold their last values while resp_valid = 0. Consumers sample them only when resp_valid = 1.

Test Plan:
- LB at 0x8000_0013, rsp data 0x0000_0000_80FF_0000_0000_0000, unsigned = 0: cmd addr 0x8000_0010, wstrb 0x00 with wen 0. The addressed lane is byte 3 = 0x00, so resp_rdata = 0x0; then the same access at 0x8000_0016 gives 0xFFFF_FFFF_FFFF_FFFF (byte 0xFF) and at 0x8000_0017 gives 0xFFFF_FFFF_FFFF_FF80.
- SH 0xBEEF to 0x8000_0106: wstrb 0xC0, wdata 0xBEEF_0000_0000_0000, addr 0x8000_0100. resp_valid exactly 2 cycles after accept, resp_err = 0.
- LW unsigned at 0x8000_0004, rsp 0x8765_4321_0000_0000: resp_rdata 0x0000_0000_8765_4321. Same access signed gives 0xFFFF_FFFF_8765_4321.
- SD at 0x8000_0004 (misaligned): cmd_valid never asserts; resp_valid next cycle with resp_err = 1. Separately, LD at 0x7FFF_FFF8: resp_err = 1 with no command.
- Load with cmd_ready low for 5 cycles: payload stable throughout, single handshake. Then with no rsp for RSP_TIMEOUT = 16 cycles: resp_err = 1; a later stray rsp_valid produces no second resp_valid.
- Reset asserted while in WAIT_RSP: next cycle req_ready = 1, cmd_valid = 0, no resp_valid. A back-to-back load issued afterwards completes normally.
